// File: rtl/mem_bus_responder.sv
// Data-memory bus target: 256x8 RAM, 4-byte MMIO window (tick, status, LED, switches), optional post-reset RAM clear.
// Optional write protection of the low address range is enabled by defining MEM_PROTECT_EN.
module mem_bus_responder #(
    parameter logic [7:0] MMIO_BASE      = 8'hFC,
    parameter bit         CLEAR_ON_RESET = 1'b0,
    parameter logic [7:0] PROT_LIMIT     = 8'h40
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       MemRead,
    input  logic       wren,
    input  logic [7:0] address,
    input  logic [7:0] data,
    output logic [7:0] q,
    input  logic [7:0] sw_in,
    output logic [7:0] led_out,
    output logic       ready,
    output logic       prot_fault
);

`ifdef MEM_PROTECT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    typedef enum logic {
        S_CLEAR,
        S_READY
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_clr_ptr;
    logic [7:0] r_tick;
    logic [7:0] r_led;
    logic [7:0] r_q;
    logic       r_prot;
    logic [7:0] r_mem [256];

    logic       w_serve;
    logic       w_in_window;
    logic [7:0] w_offset;
    logic       w_blocked;
    logic       w_ram_wr;
    logic       w_tick_wr;
    logic       w_led_wr;
    logic [7:0] w_rd_data;

    // MMIO_BASE is restricted to <= 8'hFC so the window never wraps past 8'hFF.
    assign w_serve     = (r_state == S_READY);
    assign w_in_window = (address >= MMIO_BASE) && (address <= (MMIO_BASE + 8'd3));
    assign w_offset    = address - MMIO_BASE;
    assign w_blocked   = PROT_EN && (address < PROT_LIMIT);
    assign w_ram_wr    = w_serve && wren && !w_in_window && !w_blocked;
    assign w_tick_wr   = wren && w_in_window && (w_offset == 8'd0);
    assign w_led_wr    = wren && w_in_window && (w_offset == 8'd2);

    always_comb begin
        w_rd_data = r_mem[address];
        if (w_in_window) begin
            case (w_offset)
                8'd0:    w_rd_data = r_tick;
                8'd1:    w_rd_data = {6'b0, r_prot, w_serve};
                8'd2:    w_rd_data = r_led;
                default: w_rd_data = sw_in;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        if (r_state == S_CLEAR && r_clr_ptr == 8'hFF) begin
            w_next = S_READY;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= CLEAR_ON_RESET ? S_CLEAR : S_READY;
            r_clr_ptr <= 8'h00;
            r_q       <= 8'h00;
            r_tick    <= 8'h00;
            r_led     <= 8'h00;
            r_prot    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_CLEAR) begin
                r_clr_ptr <= r_clr_ptr + 8'd1;
            end else begin
                if (MemRead) begin
                    r_q <= w_rd_data;
                end
                // A tick write takes priority over the free-running increment.
                r_tick <= w_tick_wr ? data : (r_tick + 8'd1);
                if (w_led_wr) begin
                    r_led <= data;
                end
                if (wren && !w_in_window && w_blocked) begin
                    r_prot <= 1'b1;
                end
            end
        end
    end

    // RAM contents survive reset; only the clear sequencer zeroes them.
    always_ff @(posedge clock) begin
        if (r_state == S_CLEAR) begin
            r_mem[r_clr_ptr] <= 8'h00;
        end else if (w_ram_wr) begin
            r_mem[address] <= data;
        end
    end

    assign q          = r_q;
    assign led_out    = r_led;
    assign ready      = w_serve;
    assign prot_fault = r_prot;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder (CLEAR_ON_RESET=1): directed scenarios plus randomized traffic vs a behavioural model.
module tb_mem_bus_responder;

`ifdef MEM_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       MemRead = 1'b0;
    logic       wren = 1'b0;
    logic [7:0] address = 8'h00;
    logic [7:0] data = 8'h00;
    logic [7:0] q;
    logic [7:0] sw_in = 8'h00;
    logic [7:0] led_out;
    logic       ready;
    logic       prot_fault;

    int n_chk = 0;
    int n_fail = 0;

    // Behavioural model state
    logic [7:0] m_mem [256];
    logic [7:0] m_q, m_tick, m_led;
    logic       m_prot, m_ready;
    int         m_clr;

    mem_bus_responder #(
        .MMIO_BASE     (8'hFC),
        .CLEAR_ON_RESET(1'b1),
        .PROT_LIMIT    (8'h40)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .MemRead   (MemRead),
        .wren      (wren),
        .address   (address),
        .data      (data),
        .q         (q),
        .sw_in     (sw_in),
        .led_out   (led_out),
        .ready     (ready),
        .prot_fault(prot_fault)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        m_q = 8'h00; m_tick = 8'h00; m_led = 8'h00;
        m_prot = 1'b0; m_ready = 1'b0; m_clr = 0;
    endtask

    task automatic model_edge();
        logic [7:0] a;
        logic [7:0] off;
        logic       win;
        if (reset) return;
        if (!m_ready) begin
            m_mem[m_clr] = 8'h00;
            m_clr++;
            if (m_clr == 256) m_ready = 1'b1;
            return;
        end
        a   = address;
        win = (a >= 8'hFC);
        off = a - 8'hFC;
        if (MemRead) begin
            if (!win) m_q = m_mem[a];
            else if (off == 8'd0) m_q = m_tick;
            else if (off == 8'd1) m_q = {6'b0, m_prot, 1'b1};
            else if (off == 8'd2) m_q = m_led;
            else m_q = sw_in;
        end
        m_tick = m_tick + 8'd1;
        if (wren) begin
            if (win) begin
                if (off == 8'd0) m_tick = data;
                if (off == 8'd2) m_led = data;
            end else if (PROT && a < 8'h40) begin
                m_prot = 1'b1;
            end else begin
                m_mem[a] = data;
            end
        end
    endtask

    task automatic drive(input logic mr, input logic wr, input logic [7:0] a, input logic [7:0] d);
        MemRead = mr; wren = wr; address = a; data = d;
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        #1;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (ready !== 1'b1 && cnt < 600) begin
            drive(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
            cnt++;
            step();
        end
        drive(0, 0, 8'h00, 8'h00);
    endtask

    task automatic test_reset();
        int cnt;
        drive(1, 1, 8'h33, 8'h44);
        do_reset();
        n_chk++; if (q !== 8'h00) begin n_fail++; $display("FAIL reset_q got=%h exp=00", q); end
        n_chk++; if (led_out !== 8'h00) begin n_fail++; $display("FAIL reset_led got=%h exp=00", led_out); end
        n_chk++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", ready); end
        n_chk++; if (prot_fault !== 1'b0) begin n_fail++; $display("FAIL reset_prot got=%b exp=0", prot_fault); end
        release_reset();
        wait_ready(cnt);
        n_chk++; if (cnt != 256) begin n_fail++; $display("FAIL clear_len got=%0d exp=256", cnt); end
        n_chk++; if (q !== 8'h00) begin n_fail++; $display("FAIL clear_q_held got=%h exp=00", q); end
    endtask

    task automatic test_rw();
        drive(0, 1, 8'h20, 8'h5C); step();
        drive(1, 0, 8'h20, 8'h00); step();
        n_chk++; if (q !== 8'h5C) begin n_fail++; $display("FAIL rw_read got=%h exp=5C", q); end
        drive(0, 0, 8'h20, 8'h00); step();
        n_chk++; if (q !== 8'h5C) begin n_fail++; $display("FAIL rw_hold got=%h exp=5C", q); end
    endtask

    task automatic test_read_before_write();
        drive(0, 1, 8'h21, 8'h11); step();
        drive(1, 1, 8'h21, 8'h22); step();
        n_chk++; if (q !== 8'h11) begin n_fail++; $display("FAIL rbw_old got=%h exp=11", q); end
        drive(1, 0, 8'h21, 8'h00); step();
        n_chk++; if (q !== 8'h22) begin n_fail++; $display("FAIL rbw_new got=%h exp=22", q); end
    endtask

    task automatic test_mmio();
        sw_in = 8'h3B;
        drive(1, 0, 8'hFF, 8'h00); step();
        n_chk++; if (q !== 8'h3B) begin n_fail++; $display("FAIL mmio_sw got=%h exp=3B", q); end
        drive(0, 1, 8'hFE, 8'h81); step();
        n_chk++; if (led_out !== 8'h81) begin n_fail++; $display("FAIL mmio_led got=%h exp=81", led_out); end
        drive(1, 0, 8'hFE, 8'h00); step();
        n_chk++; if (q !== 8'h81) begin n_fail++; $display("FAIL mmio_led_rd got=%h exp=81", q); end
        drive(0, 1, 8'hFC, 8'hFE); step();
        drive(1, 0, 8'hFC, 8'h00); step();
        n_chk++; if (q !== 8'hFE) begin n_fail++; $display("FAIL tick_load got=%h exp=FE", q); end
        step();
        n_chk++; if (q !== 8'hFF) begin n_fail++; $display("FAIL tick_inc got=%h exp=FF", q); end
        step();
        n_chk++; if (q !== 8'h00) begin n_fail++; $display("FAIL tick_wrap got=%h exp=00", q); end
        drive(0, 1, 8'hFD, 8'hFF); step();
        drive(1, 0, 8'hFD, 8'h00); step();
        n_chk++; if (q !== 8'h01) begin n_fail++; $display("FAIL status got=%h exp=01", q); end
        drive(0, 1, 8'hFF, 8'h55); step();
        sw_in = 8'hC4;
        drive(1, 0, 8'hFF, 8'h00); step();
        n_chk++; if (q !== 8'hC4) begin n_fail++; $display("FAIL sw_wr_ignored got=%h exp=C4", q); end
        n_chk++; if (led_out !== 8'h81) begin n_fail++; $display("FAIL led_kept got=%h exp=81", led_out); end
    endtask

    task automatic test_protect();
        int cnt;
        drive(0, 1, 8'h05, 8'h77); step();
        drive(1, 0, 8'h05, 8'h00); step();
        if (PROT) begin
            n_chk++; if (q !== 8'h00) begin n_fail++; $display("FAIL prot_blocked got=%h exp=00", q); end
            n_chk++; if (prot_fault !== 1'b1) begin n_fail++; $display("FAIL prot_flag got=%b exp=1", prot_fault); end
            drive(1, 0, 8'hFD, 8'h00); step();
            n_chk++; if (q !== 8'h03) begin n_fail++; $display("FAIL prot_status got=%h exp=03", q); end
            drive(0, 1, 8'h40, 8'h77); step();
            drive(1, 0, 8'h40, 8'h00); step();
            n_chk++; if (q !== 8'h77) begin n_fail++; $display("FAIL prot_limit_wr got=%h exp=77", q); end
            do_reset();
            n_chk++; if (prot_fault !== 1'b0) begin n_fail++; $display("FAIL prot_reset got=%b exp=0", prot_fault); end
            release_reset();
            wait_ready(cnt);
        end else begin
            n_chk++; if (q !== 8'h77) begin n_fail++; $display("FAIL noprot_wr got=%h exp=77", q); end
            n_chk++; if (prot_fault !== 1'b0) begin n_fail++; $display("FAIL noprot_flag got=%b exp=0", prot_fault); end
        end
    endtask

    task automatic test_clear_preload();
        int cnt;
        drive(0, 1, 8'h10, 8'hAA); step();
        drive(1, 0, 8'h10, 8'h00); step();
        n_chk++; if (q !== 8'hAA) begin n_fail++; $display("FAIL preload got=%h exp=AA", q); end
        do_reset();
        release_reset();
        wait_ready(cnt);
        n_chk++; if (cnt != 256) begin n_fail++; $display("FAIL clear2_len got=%0d exp=256", cnt); end
        drive(1, 0, 8'h10, 8'h00); step();
        n_chk++; if (q !== 8'h00) begin n_fail++; $display("FAIL cleared_10 got=%h exp=00", q); end
        drive(1, 0, 8'h21, 8'h00); step();
        n_chk++; if (q !== 8'h00) begin n_fail++; $display("FAIL cleared_21 got=%h exp=00", q); end
    endtask

    task automatic test_reset_mid_clear();
        int cnt;
        drive(0, 1, 8'hFE, 8'hC3); step();
        drive(0, 1, 8'h30, 8'h9D); step();
        drive(1, 0, 8'h30, 8'h00); step();
        do_reset();
        release_reset();
        for (int i = 0; i < 100; i++) begin
            drive(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
            step();
        end
        n_chk++; if (ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready got=%b exp=0", ready); end
        n_chk++; if (q !== 8'h00) begin n_fail++; $display("FAIL mid_q got=%h exp=00", q); end
        do_reset();
        n_chk++; if (led_out !== 8'h00) begin n_fail++; $display("FAIL mid_led got=%h exp=00", led_out); end
        release_reset();
        wait_ready(cnt);
        n_chk++; if (cnt != 256) begin n_fail++; $display("FAIL restart_len got=%0d exp=256", cnt); end
        drive(1, 0, 8'h30, 8'h00); step();
        n_chk++; if (q !== 8'h00) begin n_fail++; $display("FAIL restart_cleared got=%h exp=00", q); end
    endtask

    task automatic test_random();
        logic [7:0] a;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       a = 8'hFC + 8'($urandom_range(0, 3));
                1:       a = 8'($urandom_range(0, 7));
                2:       a = 8'h3E + 8'($urandom_range(0, 5));
                default: a = 8'($urandom);
            endcase
            sw_in = 8'($urandom);
            drive(1'($urandom), ($urandom_range(0, 2) == 0), a, 8'($urandom));
            step();
            n_chk++; if (q !== m_q) begin n_fail++; $display("FAIL rnd_q cyc=%0d got=%h exp=%h", i, q, m_q); end
            n_chk++; if (led_out !== m_led) begin n_fail++; $display("FAIL rnd_led cyc=%0d got=%h exp=%h", i, led_out, m_led); end
            n_chk++; if (ready !== m_ready) begin n_fail++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", i, ready, m_ready); end
            n_chk++; if (prot_fault !== m_prot) begin n_fail++; $display("FAIL rnd_prot cyc=%0d got=%b exp=%b", i, prot_fault, m_prot); end
        end
    endtask

    initial begin
        model_reset();
        #3;
        test_reset();
        test_rw();
        test_read_before_write();
        test_mmio();
        test_protect();
        test_clear_preload();
        test_reset_mid_clear();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
